// File: rtl/query_row_ingest.sv
// Query-patch ingest: Gray-code async FIFO -> word aggregator -> ping-pong row buffer.
// Optional sticky write-overflow flag is enabled with `define INGEST_OVERFLOW_FLAG_EN.
`timescale 1ns/1ps

module query_row_ingest #(
    parameter int DATA_WIDTH  = 11,
    parameter int FIFO_ASIZE  = 4,
    parameter int FETCH_WIDTH = 1,
    parameter int ADDR_WIDTH  = 7,
    parameter int DEPTH       = 128,
    localparam int W          = FETCH_WIDTH * DATA_WIDTH
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  winc,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wfull,
    input  logic                  fsm_enable,
    input  logic                  ren,
    input  logic [ADDR_WIDTH-1:0] radr,
    output logic [W-1:0]          rdata,
    output logic                  wr_bank,
    output logic                  row_done
`ifdef INGEST_OVERFLOW_FLAG_EN
    ,
    output logic                  overflow
`endif
);

    localparam int                  CW        = $clog2(FETCH_WIDTH + 1);
    localparam logic [CW-1:0]       FULL_CNT  = CW'(FETCH_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_L   = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] fifo_mem [2**FIFO_ASIZE];
    logic [FIFO_ASIZE:0]   wbin, wgray, wbin_next, wgray_next, wq1_rgray, wq2_rgray;
    logic [FIFO_ASIZE:0]   rbin, rgray, rbin_next, rgray_next, rq1_wgray, rq2_wgray;
    logic                  wpush, rempty, deq, valid, accept;
    logic [DATA_WIDTH-1:0] fifo_rdata;

    // ---------------- write domain ----------------
    assign wpush      = winc && !wfull;
    assign wbin_next  = wbin + {{FIFO_ASIZE{1'b0}}, wpush};
    assign wgray_next = (wbin_next >> 1) ^ wbin_next;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wbin      <= '0;
            wgray     <= '0;
            wfull     <= 1'b0;
            wq1_rgray <= '0;
            wq2_rgray <= '0;
        end else begin
            wbin      <= wbin_next;
            wgray     <= wgray_next;
            wq1_rgray <= rgray;
            wq2_rgray <= wq1_rgray;
            // Full when the write pointer has lapped the read pointer by exactly one depth.
            wfull     <= (wgray_next == {~wq2_rgray[FIFO_ASIZE -: 2], wq2_rgray[FIFO_ASIZE-2:0]});
        end
    end

    // NOTE: storage arrays carry no reset; only the pointers define what is valid.
    always_ff @(posedge wclk) begin
        if (wrst_n && wpush)
            fifo_mem[wbin[FIFO_ASIZE-1:0]] <= wdata;
    end

`ifdef INGEST_OVERFLOW_FLAG_EN
    always_ff @(posedge wclk) begin
        if (!wrst_n)
            overflow <= 1'b0;
        else if (winc && wfull)
            overflow <= 1'b1;
    end
`endif

    // ---------------- read domain: FIFO ----------------
    assign rbin_next  = rbin + {{FIFO_ASIZE{1'b0}}, deq};
    assign rgray_next = (rbin_next >> 1) ^ rbin_next;
    assign fifo_rdata = fifo_mem[rbin[FIFO_ASIZE-1:0]];

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            rbin      <= '0;
            rgray     <= '0;
            rempty    <= 1'b1;
            rq1_wgray <= '0;
            rq2_wgray <= '0;
        end else begin
            rbin      <= rbin_next;
            rgray     <= rgray_next;
            rq1_wgray <= wgray;
            rq2_wgray <= rq1_wgray;
            rempty    <= (rgray_next == rq2_wgray);
        end
    end

    // ---------------- aggregator ----------------
    logic [CW-1:0] count, slot;
    logic [W-1:0]  entry;

    assign valid  = (count == FULL_CNT);
    assign accept = valid && fsm_enable;
    assign deq    = !rempty && ((count < FULL_CNT) || accept);
    // A word dequeued in the same cycle as an accept starts the next entry at slot 0.
    assign slot   = accept ? '0 : count;

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            count <= '0;
            entry <= '0;
        end else begin
            if (deq)
                entry[int'(slot)*DATA_WIDTH +: DATA_WIDTH] <= fifo_rdata;
            if (accept)
                count <= deq ? CW'(1) : '0;
            else if (deq)
                count <= count + CW'(1);
        end
    end

    // ---------------- ping-pong row buffer ----------------
    logic [W-1:0]          bank_mem [2][DEPTH];
    logic [ADDR_WIDTH-1:0] wr_addr;

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            wr_addr  <= '0;
            wr_bank  <= 1'b0;
            row_done <= 1'b0;
        end else begin
            row_done <= accept && (wr_addr == LAST_ADDR);
            if (accept) begin
                if (wr_addr == LAST_ADDR) begin
                    wr_addr <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_addr <= wr_addr + ADDR_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst_n && accept)
            bank_mem[wr_bank][wr_addr] <= entry;
    end

    // The matcher reads the bank not being written, using the pre-edge bank select.
    always_ff @(posedge rclk) begin
        if (!rrst_n)
            rdata <= '0;
        else if (ren)
            rdata <= ({1'b0, radr} < DEPTH_L) ? bank_mem[~wr_bank][radr] : '0;
    end

endmodule

// File: tb/tb_query_row_ingest.sv
// Directed bench for query_row_ingest: reset, FIFO fill/drop, bank swap, ping-pong reads, mid-stream reset.
`timescale 1ns/1ps

module tb_query_row_ingest;

    localparam int DW = 11;
    localparam int AW = 7;
    localparam int W  = 11;

    logic          wclk = 1'b0;
    logic          rclk = 1'b0;
    logic          wrst_n = 1'b0;
    logic          rrst_n = 1'b0;
    logic          winc = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic          wfull;
    logic          fsm_enable = 1'b0;
    logic          ren = 1'b0;
    logic [AW-1:0] radr = '0;
    logic [W-1:0]  rdata;
    logic          wr_bank;
    logic          row_done;
`ifdef INGEST_OVERFLOW_FLAG_EN
    logic          overflow;
`endif

    int n_checks = 0;
    int n_fail = 0;
    int row_done_cnt = 0;

    query_row_ingest dut (
        .wclk       (wclk),
        .wrst_n     (wrst_n),
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .winc       (winc),
        .wdata      (wdata),
        .wfull      (wfull),
        .fsm_enable (fsm_enable),
        .ren        (ren),
        .radr       (radr),
        .rdata      (rdata),
        .wr_bank    (wr_bank),
        .row_done   (row_done)
`ifdef INGEST_OVERFLOW_FLAG_EN
        ,
        .overflow   (overflow)
`endif
    );

    // Write clock is much faster than the read clock so the FIFO fills before reads catch up.
    always #5 wclk = ~wclk;
    initial begin
        #3;
        forever #30 rclk = ~rclk;
    end

    always @(negedge rclk) if (row_done === 1'b1) row_done_cnt++;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge rclk);
        winc   = 1'b0;
        ren    = 1'b0;
        wrst_n = 1'b0;
        rrst_n = 1'b0;
        repeat (cycles) @(negedge rclk);
        wrst_n = 1'b1;
        rrst_n = 1'b1;
    endtask

    task automatic push(input logic [DW-1:0] v);
        int n;
        n = 0;
        @(negedge wclk);
        while (wfull && n < 4000) begin
            @(negedge wclk);
            n++;
        end
        if (n >= 4000) check("push_wfull_stuck", wfull, 0);
        winc  = 1'b1;
        wdata = v;
        @(negedge wclk);
        winc  = 1'b0;
    endtask

    task automatic read_word(input logic [AW-1:0] a, output logic [W-1:0] d);
        @(negedge rclk);
        ren  = 1'b1;
        radr = a;
        @(negedge rclk);
        d    = rdata;
        ren  = 1'b0;
    endtask

    task automatic wait_rows(input int target, input string tag);
        int n;
        n = 0;
        while (row_done_cnt < target && n < 3000) begin
            @(negedge rclk);
            n++;
        end
        check(tag, row_done_cnt, target);
    endtask

    logic [W-1:0] d;
    int           base;

    initial begin
        // 1. reset
        do_reset(5);
        @(negedge rclk);
        check("rst_wfull", wfull, 0);
        check("rst_rempty", dut.rempty, 1);
        check("rst_wr_bank", wr_bank, 0);
        check("rst_rdata", rdata, 0);
        check("rst_row_done", row_done, 0);
`ifdef INGEST_OVERFLOW_FLAG_EN
        check("rst_overflow", overflow, 0);
`endif

        // 2. fill with fsm_enable low: 17 back-to-back pushes, the 17th is dropped
        for (int i = 1; i <= 17; i++) begin
            @(negedge wclk);
            if (i == 17) check("full_after_16", wfull, 1);
            winc  = 1'b1;
            wdata = DW'(i);
        end
        @(negedge wclk);
        winc = 1'b0;
        check("full_after_17", wfull, 1);
`ifdef INGEST_OVERFLOW_FLAG_EN
        check("overflow_set", overflow, 1);
`endif
        fsm_enable = 1'b1;
        for (int i = 0; i < 112; i++) push(DW'(200 + i));
        wait_rows(1, "fill_row_done");
        check("fill_wr_bank", wr_bank, 1);
        read_word(AW'(0), d);  check("fill_e0", d, 1);
        read_word(AW'(7), d);  check("fill_e7", d, 8);
        read_word(AW'(15), d); check("fill_e15", d, 16);
        read_word(AW'(16), d); check("fill_e16_drop17", d, 200);

        // 3. one full bank with random write stalls
        do_reset(2);
        @(negedge rclk);
        base = row_done_cnt;
        for (int i = 0; i < 128; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge wclk);
            push(DW'(i));
        end
        wait_rows(base + 1, "bank0_row_done");
        repeat (4) @(negedge rclk);
        check("bank0_pulse_once", row_done_cnt, base + 1);
        check("bank0_wr_bank", wr_bank, 1);
        read_word(AW'(5), d); check("bank0_rd5", d, 5);
        @(negedge rclk);
        radr = AW'(9);
        @(negedge rclk);
        check("rdata_hold", rdata, 5);
        read_word(AW'(127), d); check("bank0_rd127", d, 127);

        // 4/5. ping-pong, reading the completed bank while the other fills
        for (int i = 0; i < 64; i++) push(DW'(1000 + i));
        read_word(AW'(10), d); check("read_during_fill", d, 10);
        check("mid_fill_wr_bank", wr_bank, 1);
        for (int i = 64; i < 128; i++) push(DW'(1000 + i));
        wait_rows(base + 2, "bank1_row_done");
        check("bank1_wr_bank", wr_bank, 0);
        read_word(AW'(0), d);   check("bank1_rd0", d, 1000);
        read_word(AW'(127), d); check("bank1_rd127", d, 1127);

        // 6. mid-stream reset
        for (int i = 0; i < 40; i++) push(DW'(50 + i));
        do_reset(2);
        @(negedge rclk);
        check("mid_rst_rempty", dut.rempty, 1);
        check("mid_rst_wr_addr", dut.wr_addr, 0);
        check("mid_rst_wr_bank", wr_bank, 0);
        check("mid_rst_rdata", rdata, 0);
        base = row_done_cnt;
        push(DW'(7));
        push(DW'(8));
        for (int i = 0; i < 126; i++) push(DW'(400 + i));
        wait_rows(base + 1, "post_rst_row_done");
        read_word(AW'(0), d);   check("post_rst_e0", d, 7);
        read_word(AW'(1), d);   check("post_rst_e1", d, 8);
        read_word(AW'(2), d);   check("post_rst_e2", d, 400);
        read_word(AW'(127), d); check("post_rst_e127", d, 525);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/query_row_ingest.md
Name: query_row_ingest

Overview:
- Front end of the query-patch path: patch words arrive in a producer clock domain, cross into the consumer domain through a Gray-code asynchronous FIFO, are packed FETCH_WIDTH-at-a-time by an aggregator, then stored in a two-bank (ping-pong) row buffer.
- The downstream matcher reads one completed bank while the next row is written into the other bank.

Parameters:
- DATA_WIDTH, 11, width of one patch word
- FIFO_ASIZE, 4, FIFO address bits; FIFO depth = 2^FIFO_ASIZE = 16
- FETCH_WIDTH, 1, words packed per buffer entry; entry width W = FETCH_WIDTH*DATA_WIDTH
- ADDR_WIDTH, 7, buffer address bits
- DEPTH, 128, entries per bank

Ports:
- wclk  in  1  write-domain clock
- wrst_n  in  1  write-domain reset (synchronous, active-low)
- rclk  in  1  read-domain clock (matcher clock)
- rrst_n  in  1  read-domain reset (synchronous, active-low)
- winc  in  1  push wdata into the FIFO
- wdata  in  DATA_WIDTH  word to push
- wfull  out  1  FIFO full (wclk domain)
- fsm_enable  in  1  buffer accepts writes only when high
- ren  in  1  buffer read enable
- radr  in  ADDR_WIDTH  buffer read address
- rdata  out  W  buffer read data
- wr_bank  out  1  bank currently being written
- row_done  out  1  one-cycle pulse when a bank completes and the banks swap

Behaviour:
- Reset values:
  - wrst_n low at a wclk edge: wptr=0, wfull=0.
  - rrst_n low at an rclk edge: rptr=0, rempty=1, aggregator count=0, wr_addr=0, wr_bank=0, row_done=0, rdata=0.
  - Memories are not cleared.
- FIFO:
  - Binary and Gray pointers, FIFO_ASIZE+1 bits each; each Gray pointer crosses domains through a 2-flop synchronizer.
  - A write occurs when winc && !wfull; mem[wptr] is updated at the wclk edge. winc while wfull is dropped silently, and the pointer does not move.
  - wfull is registered: next write Gray pointer == synchronized read Gray pointer with the top two bits inverted.
  - rempty is registered: next read Gray pointer == synchronized write Gray pointer.
  - Read data is show-ahead: the FIFO output equals mem[rptr] combinationally whenever !rempty.
  - A push becomes visible (rempty falls) on the 3rd rclk edge after the write edge at the latest.
  - Word order is preserved exactly.
- Aggregator (rclk domain):
  - deq = !rempty && (count<FETCH_WIDTH || accept).
  - Each dequeued word is stored in slot count, bits [(count+1)*DATA_WIDTH-1 : count*DATA_WIDTH]; first word goes in the LSBs.
  - When count==FETCH_WIDTH, the entry is valid.
  - accept = valid && fsm_enable. On accept, count returns to 0, or to 1 if a new word is dequeued in the same cycle.
  - With FETCH_WIDTH=1 and an always-ready sink, one word per rclk cycle is sustained.
- Double buffer:
  - On accept, the entry is written to bank[wr_bank][wr_addr] and wr_addr increments.
  - When wr_addr==DEPTH-1 is written: wr_addr wraps to 0, wr_bank toggles, and row_done pulses high for exactly that next cycle.
  - Reads target bank !wr_bank. When ren is high at an rclk edge, rdata = bank[!wr_bank][radr] after that edge (1-cycle latency). rdata holds its value while ren is low.
  - Same-cycle swap and read: the read uses the bank select value from before the edge.
  - fsm_enable low: nothing is written, the aggregator holds, and the FIFO backs up until wfull.
  - radr >= DEPTH: rdata is 0.

Optional Feature:
- Macro INGEST_OVERFLOW_FLAG_EN.
- Defined:
  - Adds output overflow (1 bit, wclk domain).
  - Sticky: set at the wclk edge where winc && wfull.
  - Cleared only by wrst_n.
- Undefined: port absent; dropped writes are silent.

Test Plan:
1. Reset: hold wrst_n/rrst_n low for 5 edges -> wfull=0, rempty=1, wr_bank=0, rdata=0, row_done=0.
2. Fill with fsm_enable=0:
   - Push 1..17 -> wfull rises after the 16th push and the 17th is dropped.
   - Then fsm_enable=1 -> buffer entries 0..15 = 1..16.
   - With INGEST_OVERFLOW_FLAG_EN, overflow=1.
3. One full bank, fsm_enable=1:
   - Push 0..127 with winc randomly stalled -> row_done pulses once and wr_bank=1.
   - ren with radr=5 -> rdata=5 one cycle later.
   - radr=127 -> rdata=127.
4. Ping-pong: push 128 more words 1000..1127 -> wr_bank returns to 0, and a read of radr=0 returns 1000.
5. Read during fill: while the second bank fills, read radr=10 -> rdata=10 (first bank), unaffected by ongoing writes.
6. Mid-stream reset: after 40 pushes assert both resets for 2 cycles -> rempty=1, wr_addr=0; new pushes 7,8 land at entries 0,1 of bank 0.
